// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: each channel has its own enable, 4-way rate and duty.
// Periods and duty thresholds come from elaboration-time constants, so no runtime divider is needed.
module led_blinker_multi #(
    parameter int CLK_HZ   = 25000000,
    parameter int NUM_CH   = 4,
    parameter int RATE0_HZ = 100,
    parameter int RATE1_HZ = 50,
    parameter int RATE2_HZ = 10,
    parameter int RATE3_HZ = 1,
    parameter int DUTY_W   = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NUM_CH-1:0]        i_enable,
    input  logic [2*NUM_CH-1:0]      i_rate_sel,
    input  logic [DUTY_W*NUM_CH-1:0] i_duty,
    input  logic                     i_sync,
    output logic [NUM_CH-1:0]        o_led_drive,
    output logic [NUM_CH-1:0]        o_wrap
);

    localparam int P0     = CLK_HZ / RATE0_HZ;
    localparam int P1     = CLK_HZ / RATE1_HZ;
    localparam int P2     = CLK_HZ / RATE2_HZ;
    localparam int P3     = CLK_HZ / RATE3_HZ;
    localparam int P01    = (P0 > P1) ? P0 : P1;
    localparam int P23    = (P2 > P3) ? P2 : P3;
    localparam int PMAX   = (P01 > P23) ? P01 : P23;
    localparam int CNT_W  = $clog2(PMAX);
    localparam int PROD_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("led_blinker_multi: NUM_CH must be within 1..16");
    end
    if ((CLK_HZ % RATE0_HZ) != 0 || (CLK_HZ % RATE1_HZ) != 0 ||
        (CLK_HZ % RATE2_HZ) != 0 || (CLK_HZ % RATE3_HZ) != 0) begin : g_bad_rate_div
        $error("led_blinker_multi: every rate must divide CLK_HZ exactly");
    end
    if (P0 < 2 || P1 < 2 || P2 < 2 || P3 < 2) begin : g_bad_period
        $error("led_blinker_multi: every period must be at least 2 cycles");
    end

    function automatic logic [CNT_W-1:0] period_last(input logic [1:0] r);
        case (r)
            2'd0:    return CNT_W'(P0 - 1);
            2'd1:    return CNT_W'(P1 - 1);
            2'd2:    return CNT_W'(P2 - 1);
            default: return CNT_W'(P3 - 1);
        endcase
    endfunction

    // On-time threshold (P_r * d) >> DUTY_W as a mux of constant-by-duty products.
    function automatic logic [CNT_W-1:0] thresh(input logic [1:0] r, input logic [DUTY_W-1:0] d);
        logic [PROD_W-1:0] prod;
        case (r)
            2'd0:    prod = PROD_W'(P0) * PROD_W'(d);
            2'd1:    prod = PROD_W'(P1) * PROD_W'(d);
            2'd2:    prod = PROD_W'(P2) * PROD_W'(d);
            default: prod = PROD_W'(P3) * PROD_W'(d);
        endcase
        return CNT_W'(prod >> DUTY_W);
    endfunction

    logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0][1:0]        r_q;
    logic [NUM_CH-1:0][DUTY_W-1:0] d_q;
    logic [NUM_CH-1:0]             fresh;

    // fresh marks a channel that must take a period start on its next enabled edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            fresh       <= '1;
            o_led_drive <= '0;
            o_wrap      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!i_enable[c]) begin
                    cnt[c]         <= '0;
                    r_q[c]         <= i_rate_sel[2*c +: 2];
                    d_q[c]         <= i_duty[DUTY_W*c +: DUTY_W];
                    fresh[c]       <= 1'b1;
                    o_led_drive[c] <= 1'b0;
                    o_wrap[c]      <= 1'b0;
                end else if (fresh[c] || i_sync || cnt[c] == period_last(r_q[c])) begin
                    cnt[c]         <= '0;
                    r_q[c]         <= i_rate_sel[2*c +: 2];
                    d_q[c]         <= i_duty[DUTY_W*c +: DUTY_W];
                    fresh[c]       <= 1'b0;
                    o_led_drive[c] <= thresh(i_rate_sel[2*c +: 2], i_duty[DUTY_W*c +: DUTY_W]) != '0;
                    o_wrap[c]      <= 1'b1;
                end else begin
                    cnt[c]         <= cnt[c] + CNT_ONE;
                    o_led_drive[c] <= (cnt[c] + CNT_ONE) < thresh(r_q[c], d_q[c]);
                    o_wrap[c]      <= 1'b0;
                end
            end
        end
    end

endmodule
